// File: rtl/chunked_serial_adder_pkg.sv
// Shared types and elaboration helpers for the chunked serial adder.
package chunked_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_n(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

    // Chunk counter width: clog2(N), never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunked_serial_adder_if.sv
// Start/busy/done handshake and operand/result bus for the chunked serial adder.
interface chunked_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, s, cout, ovf
    );
endinterface

// File: rtl/chunked_serial_adder_slice.sv
// Combinational CHUNK-wide ripple adder built from full-adder bit cells.
module chunked_serial_adder_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_s,
    output logic             o_cout
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_c[CHUNK];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock through a registered carry.
// state | meaning
// IDLE  | waiting for start
// RUN   | one chunk per cycle, LSB chunk first
// DONE  | one-cycle done pulse, may accept a new start
module chunked_serial_adder
    import chunked_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    chunked_serial_adder_if.slave bus
);

    localparam int N     = calc_n(WIDTH, CHUNK);
    localparam int CNT_W = cnt_width(N);

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [CNT_W-1:0] r_cnt;

    logic [CHUNK-1:0]       w_chunk_s;
    logic                   w_chunk_cout;
    logic [WIDTH+CHUNK-1:0] w_acc_cat;
    logic [WIDTH-1:0]       w_acc_next;
    logic                   w_last;
    logic                   w_accept;

    chunked_serial_adder_slice #(.CHUNK(CHUNK)) u_slice (
        .i_a    (r_a[CHUNK-1:0]),
        .i_b    (r_b[CHUNK-1:0]),
        .i_cin  (r_carry),
        .o_s    (w_chunk_s),
        .o_cout (w_chunk_cout)
    );

    // New chunk enters at the top; after N shifts the accumulator holds the full result.
    assign w_acc_cat  = {w_chunk_s, r_acc};
    assign w_acc_next = w_acc_cat[WIDTH+CHUNK-1:CHUNK];
    assign w_last     = (r_cnt == CNT_W'(N - 1));
    assign w_accept   = bus.start && (r_state != RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_acc   <= w_acc_next;
                    r_carry <= w_chunk_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_s     <= w_acc_next;
                        r_cout  <= w_chunk_cout;
                        r_ovf   <= (r_a_msb == r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb);
                    end
                end
                default: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_a     <= bus.a;
                        r_b     <= bus.sub ? ~bus.b : bus.b;
                        r_a_msb <= bus.a[WIDTH-1];
                        r_b_msb <= bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
                        r_carry <= bus.sub | bus.cin;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.s    = r_s;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed bench for chunked_serial_adder: 16/4 instance plus a 16/16 single-pass instance.
module tb_chunked_serial_adder;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    chunked_serial_adder_if #(.WIDTH(16)) bus4 ();
    chunked_serial_adder_if #(.WIDTH(16)) bus16 ();

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start on the next edge, check busy for 4 cycles, then the done cycle and results.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic [15:0] exp_s,
                          input logic exp_cout, input logic exp_ovf);
        bus4.start = 1'b1;
        bus4.a     = a;
        bus4.b     = b;
        bus4.cin   = cin;
        bus4.sub   = sub;
        tick();
        bus4.start = 1'b0;
        bus4.a     = 16'hDEAD;
        bus4.b     = 16'hBEEF;
        bus4.cin   = ~cin;
        bus4.sub   = ~sub;
        for (int i = 1; i <= 4; i++) begin
            chk({tag, "_busy"}, 32'(bus4.busy), 32'd1);
            chk({tag, "_nodone"}, 32'(bus4.done), 32'd0);
            tick();
        end
        chk({tag, "_done"}, 32'(bus4.done), 32'd1);
        chk({tag, "_idlebusy"}, 32'(bus4.busy), 32'd0);
        chk({tag, "_s"}, 32'(bus4.s), 32'(exp_s));
        chk({tag, "_cout"}, 32'(bus4.cout), 32'(exp_cout));
        chk({tag, "_ovf"}, 32'(bus4.ovf), 32'(exp_ovf));
    endtask

    initial begin
        int         n_done;
        logic [15:0] s_seen;
        n_total     = 0;
        n_bad       = 0;
        rst         = 1'b1;
        bus4.start  = 1'b0;
        bus4.a      = '0;
        bus4.b      = '0;
        bus4.cin    = 1'b0;
        bus4.sub    = 1'b0;
        bus16.start = 1'b0;
        bus16.a     = '0;
        bus16.b     = '0;
        bus16.cin   = 1'b0;
        bus16.sub   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus4.busy), 32'd0);
        chk("rst_done", 32'(bus4.done), 32'd0);
        chk("rst_s", 32'(bus4.s), 32'd0);
        chk("rst_cout", 32'(bus4.cout), 32'd0);
        chk("rst_ovf", 32'(bus4.ovf), 32'd0);
        rst = 1'b0;
        tick();

        run_op("add1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        tick();
        chk("add1_pulse", 32'(bus4.done), 32'd0);
        chk("add1_hold", 32'(bus4.s), 32'h5555);

        // Second op is launched from the DONE cycle of the first: no idle gap.
        run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("b2b", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        tick();

        run_op("cin", 16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);
        run_op("sub1", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub2", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        tick();

        // start during RUN cycle 2 must be ignored.
        bus4.start = 1'b1;
        bus4.a     = 16'h1111;
        bus4.b     = 16'h2222;
        bus4.cin   = 1'b0;
        bus4.sub   = 1'b0;
        tick();
        bus4.start = 1'b0;
        tick();
        bus4.start = 1'b1;
        bus4.a     = 16'hAAAA;
        bus4.b     = 16'h0F0F;
        bus4.sub   = 1'b1;
        tick();
        bus4.start = 1'b0;
        n_done = 0;
        s_seen = '0;
        for (int i = 0; i < 8; i++) begin
            if (bus4.done) begin
                n_done++;
                s_seen = bus4.s;
            end
            tick();
        end
        chk("ign_ndone", 32'(n_done), 32'd1);
        chk("ign_s", 32'(s_seen), 32'h3333);

        // Reset during RUN cycle 3 aborts without a done pulse.
        bus4.start = 1'b1;
        bus4.a     = 16'h0F0F;
        bus4.b     = 16'h0101;
        bus4.sub   = 1'b0;
        tick();
        bus4.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(bus4.busy), 32'd0);
        chk("abort_done", 32'(bus4.done), 32'd0);
        chk("abort_s", 32'(bus4.s), 32'd0);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus4.done) n_done++;
            tick();
        end
        chk("abort_nodone", 32'(n_done), 32'd0);
        run_op("fresh", 16'h1111, 16'h2222, 1'b1, 1'b0, 16'h3334, 1'b0, 1'b0);
        tick();

        // Single-pass instance: busy one cycle, done at t+2.
        bus16.start = 1'b1;
        bus16.a     = 16'hABCD;
        bus16.b     = 16'h1111;
        bus16.cin   = 1'b0;
        bus16.sub   = 1'b0;
        tick();
        bus16.start = 1'b0;
        chk("n1_busy", 32'(bus16.busy), 32'd1);
        chk("n1_nodone", 32'(bus16.done), 32'd0);
        tick();
        chk("n1_done", 32'(bus16.done), 32'd1);
        chk("n1_idle", 32'(bus16.busy), 32'd0);
        chk("n1_s", 32'(bus16.s), 32'hBCDE);
        chk("n1_cout", 32'(bus16.cout), 32'd0);
        chk("n1_ovf", 32'(bus16.ovf), 32'd0);
        tick();
        chk("n1_pulse", 32'(bus16.done), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
